// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit arbiter: byte width and arbiter FSM states.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] index
);

  logic [IW-1:0] cand;

  assign any = |req;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    index = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % N);
      if (req[cand]) index = cand;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart transmitter among NUM_REQ byte sources,
// with a per-byte fetch timeout that revokes a stalled grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int FETCH_TIMEOUT = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][BYTE_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]                req_last,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [BYTE_W-1:0]                 din,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic                              grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              abort,
  output state_t                            state_dbg
);

  localparam int          IW      = $clog2(NUM_REQ);
  localparam logic [15:0] TMO_MAX = 16'(FETCH_TIMEOUT - 1);

  state_t        state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] rr_ptr;
  logic [15:0]   tmo_cnt;
  logic          last_q;
  logic          pick_any;
  logic [IW-1:0] pick_idx;

  assign state_dbg = state;
  assign rr_ptr    = (last_grant == IW'(NUM_REQ - 1)) ? '0 : last_grant + IW'(1);

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .any   (pick_any),
    .index (pick_idx)
  );

  // Handshake: a byte moves when req_valid[i] and req_ready[i] are both high at a rising
  // edge; req_ready is only ever high for the granted requester while in S_FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      req_ready   <= '0;
      din         <= '0;
      tx_valid    <= 1'b0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      abort       <= 1'b0;
      tmo_cnt     <= '0;
      last_q      <= 1'b0;
      last_grant  <= IW'(NUM_REQ - 1);
    end else begin
      tx_valid <= 1'b0;
      abort    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            req_ready   <= NUM_REQ'(1) << pick_idx;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (req_valid[grant_id]) begin
            din       <= req_data[grant_id];
            last_q    <= req_last[grant_id];
            tmo_cnt   <= '0;
            req_ready <= '0;
            tx_valid  <= 1'b1;
            state     <= S_ISSUE;
          end else if (tmo_cnt == TMO_MAX) begin
            abort       <= 1'b1;
            grant_valid <= 1'b0;
            last_grant  <= grant_id;
            req_ready   <= '0;
            tmo_cnt     <= '0;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_ISSUE: state <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (!tx_ready) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tx_ready) begin
            if (last_q) begin
              grant_valid <= 1'b0;
              last_grant  <= grant_id;
              state       <= S_IDLE;
            end else begin
              req_ready <= NUM_REQ'(1) << grant_id;
              state     <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one uart transmitter (legal 2..8).
REQ-002 SHALL have parameter FETCH_TIMEOUT, default 1024, max cycles a granted requester may stall mid-packet (legal 2..65535).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-006 SHALL have port req_data  input  NUM_REQ x 8  per-requester byte.
REQ-007 SHALL have port req_last  input  NUM_REQ  marks the final byte of a packet.
REQ-008 SHALL have port req_ready  output  NUM_REQ  byte accepted when req_valid and req_ready are both high.
REQ-009 SHALL have port din  output  8  byte to the uart transmitter.
REQ-010 SHALL have port tx_valid  output  1  one-cycle start pulse to the uart transmitter.
REQ-011 SHALL have port tx_ready  input  1  uart transmitter idle flag.
REQ-012 SHALL have port grant_valid  output  1  a requester currently owns the transmitter.
REQ-013 SHALL have port grant_id  output  max(1,clog2(NUM_REQ))  index of the owning requester.
REQ-014 SHALL have port abort  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 SHALL implement states S_IDLE, S_FETCH, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE.
REQ-016 S_IDLE: if any req_valid is high, grant the first requester at or after (last_grant+1) mod NUM_REQ; load grant_id; set grant_valid; go to S_FETCH.
REQ-017 S_FETCH: req_ready[grant_id]=1, all other bits 0; on req_valid[grant_id], capture req_data into din, capture req_last, clear the timeout counter, and go to S_ISSUE.
REQ-018 req_ready SHALL be all-zero in every state other than S_FETCH.
REQ-019 S_ISSUE: tx_valid=1 for exactly this cycle; go to S_WAIT_ACK.
REQ-020 S_WAIT_ACK: wait until tx_ready=0, then go to S_WAIT_DONE.
REQ-021 S_WAIT_DONE: on tx_ready=1, if captured last=1 then clear grant_valid, set last_grant=grant_id, go to S_IDLE; else go to S_FETCH.
REQ-022 Grant SHALL be held for the whole packet; no other requester is served until the last byte completes or the grant times out.
REQ-023 Timeout counter SHALL increment each S_FETCH cycle without acceptance; when it reaches FETCH_TIMEOUT-1, pulse abort, clear grant_valid, set last_grant=grant_id, and go to S_IDLE.
REQ-024 din SHALL hold its value from capture until the next capture.
REQ-025 Latency from req_valid rising in S_IDLE (transmitter idle) to tx_valid SHALL be 2 cycles.
REQ-026 A req_valid change on a non-granted requester SHALL have no effect until the next S_IDLE arbitration.
REQ-027 If tx_ready is already high in S_WAIT_DONE, transition SHALL occur on the first S_WAIT_DONE cycle (e.g. transmitter reset mid-byte).
REQ-028 Round-robin pointer arithmetic SHALL wrap modulo NUM_REQ, including non-power-of-two values.

Reset
REQ-029 Reset SHALL force S_IDLE, req_ready=0, din=0, tx_valid=0, grant_valid=0, grant_id=0, abort=0, timeout counter=0, and last_grant=NUM_REQ-1 (requester 0 has first priority).
REQ-030 Reset asserted mid-packet SHALL drop the grant immediately with no abort pulse; the partial packet is discarded.

Structure
REQ-031 The state enum and the uart byte width constant (8) SHALL live in the shared package uart_pkg.
REQ-032 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector and pointer; outputs: any and index).

Verification
REQ-033 Single requester 0 sends 0x55 with last=1 -> tx_valid 2 cycles after req_valid, din=0x55, grant released after tx_ready returns high.
REQ-034 Requesters 0 and 2 both valid, each with a 2-byte packet -> order 0,0,2,2; no interleaving; grant_id 0 then 2.
REQ-035 All 4 requesters send 1-byte packets continuously -> grants rotate 0,1,2,3,0 with no starvation.
REQ-036 Requester 1 sends its first byte (last=0) then drops req_valid, FETCH_TIMEOUT=16 -> abort pulses 16 cycles into S_FETCH, then requester 2 is served.
REQ-037 Assert reset during S_WAIT_DONE -> all outputs reach their reset values asynchronously; after release, requester 0 is granted first.
